clic_irq_ctrl: RTL and testbench

- Core-side responder for the CLIC interrupt request interface (`irq_valid`/`irq_id`/`irq_level` in, `clic_irq` out).
- Accepts a pending interrupt, drains the pipeline, fetches the handler address from the CLIC vector table (`mtvt`), and redirects the PC.
- Holds trap state (`mepc`, `mcause`, `mil`) and keeps `clic_irq` high until `mret` retires.
- Sits between the CLIC and the RV32 core's fetch/CSR logic; no nesting (the CLIC masks `irq_valid` while `clic_irq`=1).

---
 rtl/clic_irq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_clic_irq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clic_irq_ctrl.sv
// Core-side CLIC interrupt responder: accepts an interrupt, drains the pipeline,
// reads the handler address from the vector table, redirects the PC and holds trap state until mret.
module clic_irq_ctrl #(
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        irq_valid,
    input  logic [4:0]  irq_id,
    input  logic [7:0]  irq_level,
    output logic        clic_irq,
    input  logic        mie,
    input  logic [31:0] mtvt,
    input  logic [31:0] retire_pc,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        vt_rreq,
    output logic [31:0] vt_raddr,
    input  logic        vt_rvalid,
    input  logic [31:0] vt_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        irq_ack,
    output logic [4:0]  irq_ack_id,
    input  logic        mret,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [7:0]  mil,
    output logic        mret_mie
);

    localparam int unsigned XW    = 32;
    localparam int unsigned ID_W  = 5;
    localparam int unsigned LVL_W = 8;
    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FLUSH    = 3'd1;
    localparam logic [2:0] S_FETCH    = 3'd2;
    localparam logic [2:0] S_REDIRECT = 3'd3;
    localparam logic [2:0] S_HANDLER  = 3'd4;

    logic [2:0]       state_q,    state_d;
    logic [ID_W-1:0]  id_q,       id_d;
    logic [LVL_W-1:0] lvl_q,      lvl_d;
    logic             mpie_q,     mpie_d;
    logic [LVL_W-1:0] mpil_q,     mpil_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [XW-1:0]    vt_raddr_q, vt_raddr_d;
    logic [XW-1:0]    target_q,   target_d;
    logic [XW-1:0]    mepc_q,     mepc_d;
    logic [XW-1:0]    mcause_q,   mcause_d;
    logic [LVL_W-1:0] mil_q,      mil_d;

    logic [XW-1:0]    tbl_base;
    logic             unused_mtvt_low;

    // Vector table is 64-byte aligned; low base bits carry no meaning here.
    assign tbl_base        = {mtvt[31:6], 6'b0};
    assign unused_mtvt_low = ^mtvt[5:0];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            lvl_q      <= '0;
            mpie_q     <= 1'b0;
            mpil_q     <= '0;
            cnt_q      <= '0;
            vt_raddr_q <= '0;
            target_q   <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mil_q      <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            lvl_q      <= lvl_d;
            mpie_q     <= mpie_d;
            mpil_q     <= mpil_d;
            cnt_q      <= cnt_d;
            vt_raddr_q <= vt_raddr_d;
            target_q   <= target_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mil_q      <= mil_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        lvl_d      = lvl_q;
        mpie_d     = mpie_q;
        mpil_d     = mpil_q;
        cnt_d      = cnt_q;
        vt_raddr_d = vt_raddr_q;
        target_d   = target_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mil_d      = mil_q;

        case (state_q)
            S_IDLE: begin
                if (irq_valid && mie && (irq_level != '0)) begin
                    id_d    = irq_id;
                    lvl_d   = irq_level;
                    mpie_d  = mie;
                    mpil_d  = mil_q;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_ack) begin
                    mepc_d     = retire_pc;
                    // Interrupt, minhv set until the table read lands, mpp = M.
                    mcause_d   = {1'b1, 1'b1, 2'b11, mpie_q, 3'b000, mpil_q,
                                  4'b0000, 7'b0000000, id_q};
                    cnt_d      = '0;
                    vt_raddr_d = tbl_base + XW'({id_q, 2'b00});
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (vt_rvalid) begin
                    target_d     = vt_rdata & ~XW'(1);
                    mcause_d[30] = 1'b0;
                    state_d      = S_REDIRECT;
                end else if (cnt_q == CNT_LAST) begin
                    target_d = tbl_base;
                    state_d  = S_REDIRECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REDIRECT: begin
                mil_d   = lvl_q;
                state_d = S_HANDLER;
            end
            S_HANDLER: begin
                if (mret) begin
                    mil_d   = mcause_q[23:16];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes and status are decoded straight from the state register.
    assign clic_irq       = (state_q != S_IDLE);
    assign flush_req      = (state_q == S_FLUSH);
    assign vt_rreq        = (state_q == S_FETCH);
    assign redirect_valid = (state_q == S_REDIRECT);
    assign irq_ack        = (state_q == S_REDIRECT);
    assign vt_raddr       = vt_raddr_q;
    assign redirect_pc    = target_q;
    assign irq_ack_id     = id_q;
    assign mepc           = mepc_q;
    assign mcause         = mcause_q;
    assign mil            = mil_q;
    assign mret_mie       = mcause_q[27];

endmodule

// File: tb/tb_clic_irq_ctrl.sv
// Scoreboard bench for clic_irq_ctrl: expected trap entries are queued at accept
// and compared against the DUT when redirect_valid fires.
module tb_clic_irq_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        resetb;
    logic        irq_valid;
    logic [4:0]  irq_id;
    logic [7:0]  irq_level;
    logic        clic_irq;
    logic        mie;
    logic [31:0] mtvt;
    logic [31:0] retire_pc;
    logic        flush_req;
    logic        flush_ack;
    logic        vt_rreq;
    logic [31:0] vt_raddr;
    logic        vt_rvalid;
    logic [31:0] vt_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        irq_ack;
    logic [4:0]  irq_ack_id;
    logic        mret;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [7:0]  mil;
    logic        mret_mie;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  id;
        logic [31:0] mepc;
        logic [31:0] mcause;
    } exp_t;

    exp_t     exp_q[$];
    exp_t     mon_e;
    int       checks = 0;
    int       errors = 0;
    int       ack_cnt = 0;
    int       redir_cnt = 0;
    logic [7:0] mil_m = 8'h00;

    clic_irq_ctrl #(.FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .resetb(resetb),
        .irq_valid(irq_valid), .irq_id(irq_id), .irq_level(irq_level),
        .clic_irq(clic_irq), .mie(mie), .mtvt(mtvt), .retire_pc(retire_pc),
        .flush_req(flush_req), .flush_ack(flush_ack),
        .vt_rreq(vt_rreq), .vt_raddr(vt_raddr), .vt_rvalid(vt_rvalid), .vt_rdata(vt_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .irq_ack(irq_ack), .irq_ack_id(irq_ack_id), .mret(mret),
        .mepc(mepc), .mcause(mcause), .mil(mil), .mret_mie(mret_mie)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Redirect monitor: every redirect must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetb === 1'b1 && redirect_valid === 1'b1) begin
            redir_cnt++;
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("redirect_pc", redirect_pc, mon_e.pc);
                chk("irq_ack_id", 32'(irq_ack_id), 32'(mon_e.id));
                chk("irq_ack", 32'(irq_ack), 32'(1));
                chk("mepc", mepc, mon_e.mepc);
                chk("mcause", mcause, mon_e.mcause);
            end
        end
        if (resetb === 1'b1 && irq_ack === 1'b1) ack_cnt++;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_clic_irq"}, 32'(clic_irq), 32'(0));
        chk({tag, "_flush_req"}, 32'(flush_req), 32'(0));
        chk({tag, "_vt_rreq"}, 32'(vt_rreq), 32'(0));
        chk({tag, "_vt_raddr"}, vt_raddr, 32'(0));
        chk({tag, "_redirect_valid"}, 32'(redirect_valid), 32'(0));
        chk({tag, "_redirect_pc"}, redirect_pc, 32'(0));
        chk({tag, "_irq_ack"}, 32'(irq_ack), 32'(0));
        chk({tag, "_irq_ack_id"}, 32'(irq_ack_id), 32'(0));
        chk({tag, "_mepc"}, mepc, 32'(0));
        chk({tag, "_mcause"}, mcause, 32'(0));
        chk({tag, "_mil"}, 32'(mil), 32'(0));
    endtask

    // rv_dly: FETCH cycle index (0-based) carrying vt_rvalid, or -1 for none.
    task automatic do_trap(input logic [4:0] id, input logic [7:0] lvl,
                           input logic [31:0] tvt, input logic [31:0] rpc,
                           input logic [31:0] rdata, input int ack_dly,
                           input int rv_dly, input bit mret_fetch);
        exp_t e;
        int   n;
        bit   hit;
        hit      = (rv_dly >= 0) && (rv_dly < int'(TO));
        e.pc     = hit ? (rdata & 32'hFFFF_FFFE) : {tvt[31:6], 6'b0};
        e.id     = id;
        e.mepc   = rpc;
        e.mcause = {1'b1, ~hit, 2'b11, 1'b1, 3'b000, mil_m, 4'b0000, 7'b0000000, id};
        exp_q.push_back(e);

        mie = 1'b1; irq_valid = 1'b1; irq_id = id; irq_level = lvl;
        mtvt = tvt; retire_pc = rpc; vt_rdata = rdata;
        step();
        irq_valid = 1'b0;
        chk("accept_flush_req", 32'(flush_req), 32'(1));
        chk("accept_clic_irq", 32'(clic_irq), 32'(1));
        repeat (ack_dly) step();
        chk("flush_hold", 32'(flush_req), 32'(1));
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        chk("vt_raddr", vt_raddr, {tvt[31:6], 6'b0} + 32'({id, 2'b00}));
        n = 0;
        while (vt_rreq === 1'b1 && n < 300) begin
            if (n == rv_dly) vt_rvalid = 1'b1;
            if (mret_fetch && n == 0) mret = 1'b1;
            n++;
            step();
            vt_rvalid = 1'b0;
            mret = 1'b0;
        end
        chk("vt_rreq_cycles", 32'(n), hit ? 32'(rv_dly + 1) : 32'(TO));
        chk("redirect_valid", 32'(redirect_valid), 32'(1));
        step();
        chk("handler_mil", 32'(mil), 32'(lvl));
        chk("handler_redirect_off", 32'(redirect_valid), 32'(0));
        chk("handler_clic_irq", 32'(clic_irq), 32'(1));
        chk("handler_mret_mie", 32'(mret_mie), 32'(1));
        mil_m = lvl;
    endtask

    task automatic do_return();
        mret = 1'b1;
        step();
        mret = 1'b0;
        chk("ret_clic_irq", 32'(clic_irq), 32'(0));
        chk("ret_mil", 32'(mil), 32'(0));
        chk("ret_mret_mie", 32'(mret_mie), 32'(1));
        mil_m = 8'h00;
    endtask

    initial begin
        resetb = 1'b0; irq_valid = 1'b0; irq_id = '0; irq_level = '0; mie = 1'b0;
        mtvt = '0; retire_pc = '0; flush_ack = 1'b0; vt_rvalid = 1'b0;
        vt_rdata = '0; mret = 1'b0;
        repeat (3) step();
        check_zero("reset");
        resetb = 1'b1;
        step();

        // Basic entry and return, then immediate re-accept.
        do_trap(5'd7, 8'h80, 32'h0000_1040, 32'h0000_0200, 32'h0000_3001, 1, 0, 1'b0);
        chk("basic_mepc", mepc, 32'h0000_0200);
        chk("basic_mcause", mcause, 32'hB800_0007);
        do_return();
        do_trap(5'd12, 8'h10, 32'h0000_8000, 32'h0000_0444, 32'h0000_9004, 0, 0, 1'b0);
        do_return();

        // Masked by mie.
        mie = 1'b0; irq_valid = 1'b1; irq_id = 5'd2; irq_level = 8'h40;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("masked_flush_req", 32'(flush_req), 32'(0));
        end
        chk("masked_clic_irq", 32'(clic_irq), 32'(0));
        do_trap(5'd2, 8'h40, 32'h0000_4000, 32'h0000_0500, 32'h0000_5555, 0, 0, 1'b0);
        do_return();

        // Level zero is never eligible.
        mie = 1'b1; irq_valid = 1'b1; irq_level = 8'h00;
        repeat (5) step();
        chk("level0_clic_irq", 32'(clic_irq), 32'(0));
        irq_valid = 1'b0;

        // Vector fetch timeout, and rvalid landing in the last cycle.
        do_trap(5'd3, 8'h22, 32'h0000_2047, 32'h0000_0600, 32'h0000_7777, 0, -1, 1'b0);
        do_return();
        do_trap(5'd3, 8'h22, 32'h0000_2047, 32'h0000_0604, 32'h0000_7777, 0, 3, 1'b0);
        do_return();

        // Delayed flush_ack and a stray mret during FETCH.
        do_trap(5'd31, 8'hFF, 32'hFFFF_FFC0, 32'h0000_0800, 32'h1234_5679, 10, 1, 1'b1);
        do_return();

        // Async reset in FETCH aborts the trap.
        mie = 1'b1; irq_valid = 1'b1; irq_id = 5'd9; irq_level = 8'h05;
        step();
        irq_valid = 1'b0; flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        chk("rst_pre_vt_rreq", 32'(vt_rreq), 32'(1));
        #2 resetb = 1'b0;
        #1 check_zero("rst_fetch");
        step();
        step();
        resetb = 1'b1;
        vt_rvalid = 1'b1;
        repeat (10) step();
        vt_rvalid = 1'b0;
        chk("rst_no_redirect", 32'(redir_cnt), 32'(6));
        chk("rst_no_ack", 32'(ack_cnt), 32'(6));
        chk("rst_clic_irq", 32'(clic_irq), 32'(0));
        chk("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
